// File: rtl/score_pkg.sv
// Shared types and helpers for the music-score note scheduler.
package score_pkg;

    localparam logic [3:0] DUR_EIGHTH  = 4'b0001;
    localparam logic [3:0] DUR_QUARTER = 4'b0010;
    localparam logic [3:0] DUR_HALF    = 4'b0100;
    localparam logic [3:0] DUR_WHOLE   = 4'b1000;

    localparam int NOTE_W  = 8;
    localparam int DUR_W   = 4;
    localparam int ENTRY_W = NOTE_W + DUR_W;

    typedef struct packed {
        logic [3:0] letter;
        logic [2:0] octave;
        logic       accidental;
    } note_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VB = 2'd1,
        ST_COMMIT  = 2'd2,
        ST_CLEAR   = 2'd3
    } sched_state_t;

    // Number of staff columns a note of the given duration occupies.
    function automatic logic [2:0] dur_span(input logic [3:0] dur);
        case (dur)
            DUR_EIGHTH:  return 3'd1;
            DUR_QUARTER: return 3'd1;
            DUR_HALF:    return 3'd2;
            DUR_WHOLE:   return 3'd4;
            default:     return 3'd1;
        endcase
    endfunction

    // True when exactly one bit of the duration code is set.
    function automatic logic is_onehot4(input logic [3:0] d);
        return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/note_fifo.sv
// Synchronous show-ahead FIFO holding pending {note, duration} events.
module note_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_LIM = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == DEPTH_LIM);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Qualify requests against occupancy and advance pointers and count.
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// Buffers note events and commits one per frame during vertical blanking,
// assigning each a staff position and clearing the page when it fills.
module note_scheduler
    import score_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int SLOTS_PER_LINE = 16,
    parameter int LINES          = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [7:0]                        note_in,
    input  logic [3:0]                        duration_in,
    input  logic                              new_note,
    input  logic                              vblank_start,
    output logic [7:0]                        note_out,
    output logic [3:0]                        duration_out,
    output logic [$clog2(SLOTS_PER_LINE)-1:0] slot_col,
    output logic [$clog2(LINES)-1:0]          slot_line,
    output logic                              note_valid,
    output logic                              clear_page,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
    output logic                              overflow,
    output logic                              bad_dur
);

    localparam int COL_W  = $clog2(SLOTS_PER_LINE);
    localparam int LINE_W = $clog2(LINES);
    localparam logic [COL_W:0]  SLOTS_LIM = (COL_W + 1)'(SLOTS_PER_LINE);
    localparam logic [LINE_W:0] LINES_LIM = (LINE_W + 1)'(LINES);

    // Edge detect and push qualification
    logic new_prev_q, new_prev_d;
    logic candidate, dur_ok, push_ok, pop;

    // FIFO interface
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] head;
    note_t              head_note;
    logic [3:0]         head_dur;

    // Placement arithmetic
    logic [COL_W:0]   span_w, place_sum, next_sum;
    logic             fits, page_full;
    logic [COL_W-1:0] place_col;
    logic [LINE_W:0]  place_line;

    // State, cursor and registered outputs
    sched_state_t     state_q, state_d;
    logic [COL_W-1:0] cur_col_q, cur_col_d;
    logic [LINE_W:0]  cur_line_q, cur_line_d;
    logic [7:0]       note_out_q, note_out_d;
    logic [3:0]       duration_out_q, duration_out_d;
    logic [COL_W-1:0] slot_col_q, slot_col_d;
    logic [LINE_W-1:0] slot_line_q, slot_line_d;
    logic             note_valid_q, note_valid_d;
    logic             clear_page_q, clear_page_d;
    logic             overflow_q, overflow_d;
    logic             bad_dur_q, bad_dur_d;

    note_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_ok),
        .wr_data ({note_in, duration_in}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Rising-edge detect on new_note and validation of the incoming event.
    always_comb begin
        new_prev_d = new_note;
        candidate  = new_note & ~new_prev_q;
        dur_ok     = is_onehot4(duration_in);
        push_ok    = candidate & dur_ok & ~fifo_full;
        overflow_d = overflow_q | (candidate & dur_ok & fifo_full);
        bad_dur_d  = bad_dur_q | (candidate & ~dur_ok);
    end

    // Where the FIFO head would land given the current cursor. The cursor line
    // is one bit wider so "one past the last line" marks a full page.
    always_comb begin
        head_note  = note_t'(head[ENTRY_W-1:DUR_W]);
        head_dur   = head[DUR_W-1:0];
        span_w     = (COL_W + 1)'(dur_span(head_dur));
        place_sum  = {1'b0, cur_col_q} + span_w;
        fits       = (place_sum <= SLOTS_LIM);
        place_col  = fits ? cur_col_q : '0;
        place_line = fits ? cur_line_q : cur_line_q + (LINE_W + 1)'(1);
        page_full  = (place_line >= LINES_LIM);
        next_sum   = {1'b0, place_col} + span_w;
    end

    // Scheduler FSM: the commit or clear happens on the vblank edge, so the
    // COMMIT and CLEAR states are the single cycle in which the pulse is seen.
    always_comb begin
        state_d        = state_q;
        pop            = 1'b0;
        cur_col_d      = cur_col_q;
        cur_line_d     = cur_line_q;
        note_out_d     = note_out_q;
        duration_out_d = duration_out_q;
        slot_col_d     = slot_col_q;
        slot_line_d    = slot_line_q;
        note_valid_d   = 1'b0;
        clear_page_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty || push_ok) begin
                    state_d = ST_WAIT_VB;
                end
            end
            ST_WAIT_VB: begin
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                end else if (vblank_start) begin
                    if (page_full) begin
                        clear_page_d = 1'b1;
                        cur_col_d    = '0;
                        cur_line_d   = '0;
                        state_d      = ST_CLEAR;
                    end else begin
                        pop            = 1'b1;
                        note_valid_d   = 1'b1;
                        note_out_d     = head_note;
                        duration_out_d = head_dur;
                        slot_col_d     = place_col;
                        slot_line_d    = place_line[LINE_W-1:0];
                        if (next_sum == SLOTS_LIM) begin
                            cur_col_d  = '0;
                            cur_line_d = place_line + (LINE_W + 1)'(1);
                        end else begin
                            cur_col_d  = next_sum[COL_W-1:0];
                            cur_line_d = place_line;
                        end
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                state_d = (!fifo_empty || push_ok) ? ST_WAIT_VB : ST_IDLE;
            end
            ST_CLEAR: begin
                state_d = ST_WAIT_VB;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, cursor, flag and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            new_prev_q     <= 1'b1;
            cur_col_q      <= '0;
            cur_line_q     <= '0;
            note_out_q     <= '0;
            duration_out_q <= '0;
            slot_col_q     <= '0;
            slot_line_q    <= '0;
            note_valid_q   <= 1'b0;
            clear_page_q   <= 1'b0;
            overflow_q     <= 1'b0;
            bad_dur_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            new_prev_q     <= new_prev_d;
            cur_col_q      <= cur_col_d;
            cur_line_q     <= cur_line_d;
            note_out_q     <= note_out_d;
            duration_out_q <= duration_out_d;
            slot_col_q     <= slot_col_d;
            slot_line_q    <= slot_line_d;
            note_valid_q   <= note_valid_d;
            clear_page_q   <= clear_page_d;
            overflow_q     <= overflow_d;
            bad_dur_q      <= bad_dur_d;
        end
    end

    assign note_out     = note_out_q;
    assign duration_out = duration_out_q;
    assign slot_col     = slot_col_q;
    assign slot_line    = slot_line_q;
    assign note_valid   = note_valid_q;
    assign clear_page   = clear_page_q;
    assign overflow     = overflow_q;
    assign bad_dur      = bad_dur_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Directed table-driven bench for note_scheduler plus hand-written sequences
// for overflow, reset mid-queue, line wrap and page clear.
module tb_note_scheduler;

    logic       clk;
    logic       reset;
    logic [7:0] note_in;
    logic [3:0] duration_in;
    logic       new_note;
    logic       vblank_start;
    logic [7:0] note_out;
    logic [3:0] duration_out;
    logic [3:0] slot_col;
    logic [1:0] slot_line;
    logic       note_valid;
    logic       clear_page;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       bad_dur;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       rst;
        logic       nn;
        logic [7:0] note;
        logic [3:0] dur;
        logic       vb;
        logic       valid;
        logic       clr;
        logic [7:0] nout;
        logic [3:0] dout;
        logic [3:0] col;
        logic [1:0] line;
        logic [3:0] cnt;
        logic       ovf;
        logic       bad;
    } vec_t;

    localparam int NVEC = 30;
    vec_t vecs [NVEC];

    note_scheduler #(
        .FIFO_DEPTH     (8),
        .SLOTS_PER_LINE (16),
        .LINES          (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .note_in      (note_in),
        .duration_in  (duration_in),
        .new_note     (new_note),
        .vblank_start (vblank_start),
        .note_out     (note_out),
        .duration_out (duration_out),
        .slot_col     (slot_col),
        .slot_line    (slot_line),
        .note_valid   (note_valid),
        .clear_page   (clear_page),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .bad_dur      (bad_dur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then settle just after the rising edge.
    task automatic applyStimulus(input logic rst, input logic nn, input logic [7:0] nt,
                                 input logic [3:0] dur, input logic vb);
        reset        = rst;
        new_note     = nn;
        note_in      = nt;
        duration_in  = dur;
        vblank_start = vb;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(input logic rst, input logic nn, input logic [7:0] note,
                                   input logic [3:0] dur, input logic vb, input logic valid,
                                   input logic clr, input logic [7:0] nout, input logic [3:0] dout,
                                   input logic [3:0] col, input logic [1:0] line,
                                   input logic [3:0] cnt, input logic ovf, input logic bad);
        vec_t v;
        v.rst = rst; v.nn = nn; v.note = note; v.dur = dur; v.vb = vb;
        v.valid = valid; v.clr = clr; v.nout = nout; v.dout = dout;
        v.col = col; v.line = line; v.cnt = cnt; v.ovf = ovf; v.bad = bad;
        return v;
    endfunction

    task automatic checkVector(input string tag, input vec_t v);
        checkOutput({tag, ".note_valid"},   16'(note_valid),   16'(v.valid));
        checkOutput({tag, ".clear_page"},   16'(clear_page),   16'(v.clr));
        checkOutput({tag, ".note_out"},     16'(note_out),     16'(v.nout));
        checkOutput({tag, ".duration_out"}, 16'(duration_out), 16'(v.dout));
        checkOutput({tag, ".slot_col"},     16'(slot_col),     16'(v.col));
        checkOutput({tag, ".slot_line"},    16'(slot_line),    16'(v.line));
        checkOutput({tag, ".fifo_count"},   16'(fifo_count),   16'(v.cnt));
        checkOutput({tag, ".overflow"},     16'(overflow),     16'(v.ovf));
        checkOutput({tag, ".bad_dur"},      16'(bad_dur),      16'(v.bad));
    endtask

    task automatic pushNote(input logic [7:0] nt, input logic [3:0] dur);
        applyStimulus(1'b0, 1'b1, nt, dur, 1'b0);
        applyStimulus(1'b0, 1'b0, nt, dur, 1'b0);
    endtask

    // Push one note into an idle scheduler and expect it at (col, line) on the next vblank.
    task automatic commitOne(input string tag, input logic [7:0] nt, input logic [3:0] dur,
                             input logic [3:0] col, input logic [1:0] line);
        pushNote(nt, dur);
        applyStimulus(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
        checkOutput({tag, ".note_valid"}, 16'(note_valid), 16'd1);
        checkOutput({tag, ".clear_page"}, 16'(clear_page), 16'd0);
        checkOutput({tag, ".note_out"},   16'(note_out),   16'(nt));
        checkOutput({tag, ".dur_out"},    16'(duration_out), 16'(dur));
        checkOutput({tag, ".slot_col"},   16'(slot_col),   16'(col));
        checkOutput({tag, ".slot_line"},  16'(slot_line),  16'(line));
        checkOutput({tag, ".fifo_count"}, 16'(fifo_count), 16'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
        checkOutput({tag, ".pulse_end"},  16'(note_valid), 16'd0);
    endtask

    // Safety net so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //                 rst nn note   dur   vb  val clr nout   dout  col    line  cnt   ovf bad
        vecs[0]  = mkVec(1, 1, 8'h00, 4'h0, 0,  0, 0, 8'h00, 4'h0, 4'd0, 2'd0, 4'd0, 0, 0);
        vecs[1]  = mkVec(1, 1, 8'h00, 4'h0, 0,  0, 0, 8'h00, 4'h0, 4'd0, 2'd0, 4'd0, 0, 0);
        vecs[2]  = mkVec(0, 1, 8'h00, 4'h0, 0,  0, 0, 8'h00, 4'h0, 4'd0, 2'd0, 4'd0, 0, 0);
        vecs[3]  = mkVec(0, 1, 8'h00, 4'h0, 0,  0, 0, 8'h00, 4'h0, 4'd0, 2'd0, 4'd0, 0, 0);
        vecs[4]  = mkVec(0, 0, 8'h00, 4'h0, 0,  0, 0, 8'h00, 4'h0, 4'd0, 2'd0, 4'd0, 0, 0);
        vecs[5]  = mkVec(0, 1, 8'h18, 4'h2, 0,  0, 0, 8'h00, 4'h0, 4'd0, 2'd0, 4'd1, 0, 0);
        vecs[6]  = mkVec(0, 0, 8'h18, 4'h2, 1,  1, 0, 8'h18, 4'h2, 4'd0, 2'd0, 4'd0, 0, 0);
        vecs[7]  = mkVec(0, 0, 8'h18, 4'h2, 0,  0, 0, 8'h18, 4'h2, 4'd0, 2'd0, 4'd0, 0, 0);
        vecs[8]  = mkVec(0, 0, 8'h00, 4'h0, 1,  0, 0, 8'h18, 4'h2, 4'd0, 2'd0, 4'd0, 0, 0);
        vecs[9]  = mkVec(0, 1, 8'h25, 4'h3, 0,  0, 0, 8'h18, 4'h2, 4'd0, 2'd0, 4'd0, 0, 1);
        vecs[10] = mkVec(0, 0, 8'h25, 4'h3, 0,  0, 0, 8'h18, 4'h2, 4'd0, 2'd0, 4'd0, 0, 1);
        vecs[11] = mkVec(0, 1, 8'h2A, 4'h1, 0,  0, 0, 8'h18, 4'h2, 4'd0, 2'd0, 4'd1, 0, 1);
        vecs[12] = mkVec(0, 0, 8'h2A, 4'h1, 0,  0, 0, 8'h18, 4'h2, 4'd0, 2'd0, 4'd1, 0, 1);
        vecs[13] = mkVec(0, 1, 8'h3C, 4'h4, 0,  0, 0, 8'h18, 4'h2, 4'd0, 2'd0, 4'd2, 0, 1);
        vecs[14] = mkVec(0, 0, 8'h3C, 4'h4, 0,  0, 0, 8'h18, 4'h2, 4'd0, 2'd0, 4'd2, 0, 1);
        vecs[15] = mkVec(0, 1, 8'h41, 4'h8, 0,  0, 0, 8'h18, 4'h2, 4'd0, 2'd0, 4'd3, 0, 1);
        vecs[16] = mkVec(0, 0, 8'h41, 4'h8, 1,  1, 0, 8'h2A, 4'h1, 4'd1, 2'd0, 4'd2, 0, 1);
        vecs[17] = mkVec(0, 0, 8'h00, 4'h0, 1,  0, 0, 8'h2A, 4'h1, 4'd1, 2'd0, 4'd2, 0, 1);
        vecs[18] = mkVec(0, 0, 8'h00, 4'h0, 0,  0, 0, 8'h2A, 4'h1, 4'd1, 2'd0, 4'd2, 0, 1);
        vecs[19] = mkVec(0, 0, 8'h00, 4'h0, 1,  1, 0, 8'h3C, 4'h4, 4'd2, 2'd0, 4'd1, 0, 1);
        vecs[20] = mkVec(0, 0, 8'h00, 4'h0, 0,  0, 0, 8'h3C, 4'h4, 4'd2, 2'd0, 4'd1, 0, 1);
        vecs[21] = mkVec(0, 0, 8'h00, 4'h0, 1,  1, 0, 8'h41, 4'h8, 4'd4, 2'd0, 4'd0, 0, 1);
        vecs[22] = mkVec(0, 0, 8'h00, 4'h0, 1,  0, 0, 8'h41, 4'h8, 4'd4, 2'd0, 4'd0, 0, 1);
        vecs[23] = mkVec(0, 0, 8'h00, 4'h0, 1,  0, 0, 8'h41, 4'h8, 4'd4, 2'd0, 4'd0, 0, 1);
        vecs[24] = mkVec(0, 1, 8'h50, 4'h2, 0,  0, 0, 8'h41, 4'h8, 4'd4, 2'd0, 4'd1, 0, 1);
        vecs[25] = mkVec(0, 0, 8'h50, 4'h2, 0,  0, 0, 8'h41, 4'h8, 4'd4, 2'd0, 4'd1, 0, 1);
        vecs[26] = mkVec(0, 1, 8'h52, 4'h2, 1,  1, 0, 8'h50, 4'h2, 4'd8, 2'd0, 4'd1, 0, 1);
        vecs[27] = mkVec(0, 0, 8'h00, 4'h0, 0,  0, 0, 8'h50, 4'h2, 4'd8, 2'd0, 4'd1, 0, 1);
        vecs[28] = mkVec(0, 0, 8'h00, 4'h0, 1,  1, 0, 8'h52, 4'h2, 4'd9, 2'd0, 4'd0, 0, 1);
        vecs[29] = mkVec(0, 0, 8'h00, 4'h0, 0,  0, 0, 8'h52, 4'h2, 4'd9, 2'd0, 4'd0, 0, 1);

        $display("[TB] table vectors");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].nn, vecs[i].note, vecs[i].dur, vecs[i].vb);
            checkVector($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset with five queued entries and a vblank pending.
        $display("[TB] reset mid-queue");
        for (int i = 0; i < 5; i++) pushNote(8'h60 + 8'(i), 4'h2);
        checkOutput("rst.count_before", 16'(fifo_count), 16'd5);
        applyStimulus(1'b1, 1'b0, 8'h00, 4'h0, 1'b1);
        checkOutput("rst.count",      16'(fifo_count),   16'd0);
        checkOutput("rst.note_valid", 16'(note_valid),   16'd0);
        checkOutput("rst.note_out",   16'(note_out),     16'd0);
        checkOutput("rst.dur_out",    16'(duration_out), 16'd0);
        checkOutput("rst.slot_col",   16'(slot_col),     16'd0);
        checkOutput("rst.bad_dur",    16'(bad_dur),      16'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
        checkOutput("rst.after_vb",   16'(note_valid),   16'd0);
        checkOutput("rst.after_cnt",  16'(fifo_count),   16'd0);

        // Nine pushes without vblank, then drain; a push during the first pop is dropped.
        $display("[TB] overflow");
        for (int i = 0; i < 8; i++) pushNote(8'h10 + 8'(i), 4'h2);
        checkOutput("ovf.count8",  16'(fifo_count), 16'd8);
        checkOutput("ovf.flag_lo", 16'(overflow),   16'd0);
        pushNote(8'h18, 4'h2);
        checkOutput("ovf.count9",  16'(fifo_count), 16'd8);
        checkOutput("ovf.flag_hi", 16'(overflow),   16'd1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, (i == 0), 8'h99, 4'h2, 1'b1);
            checkOutput($sformatf("ovf.valid%0d", i), 16'(note_valid), 16'd1);
            checkOutput($sformatf("ovf.note%0d", i),  16'(note_out),   16'(8'h10 + 8'(i)));
            checkOutput($sformatf("ovf.col%0d", i),   16'(slot_col),   16'(i));
            checkOutput($sformatf("ovf.cnt%0d", i),   16'(fifo_count), 16'(7 - i));
            applyStimulus(1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
        checkOutput("ovf.drained_valid", 16'(note_valid), 16'd0);
        checkOutput("ovf.drained_cnt",   16'(fifo_count), 16'd0);

        // Line wrap and page clear from a fresh cursor.
        $display("[TB] line wrap and page clear");
        applyStimulus(1'b1, 1'b0, 8'h00, 4'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
        for (int i = 0; i < 14; i++) commitOne($sformatf("l0q%0d", i), 8'h30, 4'h2, 4'(i), 2'd0);
        commitOne("half_at14", 8'h3C, 4'h4, 4'd14, 2'd0);
        for (int i = 0; i < 14; i++) commitOne($sformatf("l1q%0d", i), 8'h31, 4'h2, 4'(i), 2'd1);
        commitOne("whole_wrap", 8'h41, 4'h8, 4'd0, 2'd2);
        for (int i = 0; i < 12; i++) commitOne($sformatf("l2q%0d", i), 8'h32, 4'h1, 4'(4 + i), 2'd2);
        for (int i = 0; i < 15; i++) commitOne($sformatf("l3q%0d", i), 8'h33, 4'h2, 4'(i), 2'd3);
        pushNote(8'h77, 4'h4);
        checkOutput("pg.count_before", 16'(fifo_count), 16'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
        checkOutput("pg.clear",       16'(clear_page), 16'd1);
        checkOutput("pg.no_valid",    16'(note_valid), 16'd0);
        checkOutput("pg.count_keep",  16'(fifo_count), 16'd1);
        checkOutput("pg.note_held",   16'(note_out),   16'h33);
        applyStimulus(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
        checkOutput("pg.clear_end",   16'(clear_page), 16'd0);
        checkOutput("pg.ignored_vb",  16'(note_valid), 16'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
        checkOutput("pg.valid",       16'(note_valid), 16'd1);
        checkOutput("pg.note",        16'(note_out),   16'h77);
        checkOutput("pg.col",         16'(slot_col),   16'd0);
        checkOutput("pg.line",        16'(slot_line),  16'd0);
        checkOutput("pg.count_after", 16'(fifo_count), 16'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
        commitOne("pg.next", 8'h78, 4'h2, 4'd2, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
